// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite motion sequencer: screen limits,
// sequencer state encoding, axis selector and the 6-bit border palette.
package sprite_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        COMMIT
    } state_t;

    typedef enum logic {
        AXIS_X,
        AXIS_Y
    } axis_t;

    localparam logic [5:0] BORDER_BLACK   = 6'b00_00_00;
    localparam logic [5:0] BORDER_BLUE    = 6'b00_00_11;
    localparam logic [5:0] BORDER_GREEN   = 6'b00_11_00;
    localparam logic [5:0] BORDER_CYAN    = 6'b00_11_11;
    localparam logic [5:0] BORDER_RED     = 6'b11_00_00;
    localparam logic [5:0] BORDER_MAGENTA = 6'b11_00_11;
    localparam logic [5:0] BORDER_YELLOW  = 6'b11_11_00;
    localparam logic [5:0] BORDER_WHITE   = 6'b11_11_11;

    function automatic logic [5:0] border_color(input logic [2:0] idx);
        case (idx)
            3'd0:    border_color = BORDER_BLACK;
            3'd1:    border_color = BORDER_BLUE;
            3'd2:    border_color = BORDER_GREEN;
            3'd3:    border_color = BORDER_CYAN;
            3'd4:    border_color = BORDER_RED;
            3'd5:    border_color = BORDER_MAGENTA;
            3'd6:    border_color = BORDER_YELLOW;
            default: border_color = BORDER_WHITE;
        endcase
    endfunction

endpackage

// File: rtl/axis_bounce_step.sv
// Combinational single-axis bounce/step: advances a position by speed s in the
// current direction, or reverses direction (position held) when the move would leave the screen.
module axis_bounce_step (
    input  logic [9:0]  p,
    input  logic [3:0]  s,
    input  logic        dir,
    input  logic [10:0] extent,
    input  logic [10:0] limit,
    output logic [9:0]  p_next,
    output logic        dir_next
);

    logic [10:0] far_edge;

    always_comb begin
        far_edge = {1'b0, p} + extent + {7'b0, s};
        p_next   = p;
        dir_next = dir;
        if (s != 4'd0) begin
            if (!dir) begin
                if (far_edge <= limit) p_next = p + {6'b0, s};
                else                   dir_next = 1'b1;
            end else begin
                if (p >= {6'b0, s}) p_next = p - {6'b0, s};
                else                dir_next = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sprite_motion_sequencer.sv
// Per-frame sprite motion sequencer: walks every sprite axis through one shared
// bounce unit, then commits all positions at once. Define SPRITE_COLOR_CYCLE_EN for the border colour cycle.
module sprite_motion_sequencer
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES    = 4,
    parameter int unsigned SPRITE_W       = 50,
    parameter int unsigned SPRITE_H       = 50,
    parameter int unsigned COLOR_INTERVAL = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic [8*NUM_SPRITES-1:0]  speed_in,
    output logic [10*NUM_SPRITES-1:0] pos_x,
    output logic [10*NUM_SPRITES-1:0] pos_y,
    output logic [NUM_SPRITES-1:0]    dir_x,
    output logic [NUM_SPRITES-1:0]    dir_y,
    output logic [2:0]                color_state,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    state_t                    state;
    axis_t                     axis;
    logic [2:0]                idx;
    logic [8*NUM_SPRITES-1:0]  speed_sh;
    logic [10*NUM_SPRITES-1:0] wx, wy;
    logic [NUM_SPRITES-1:0]    wdx, wdy;

    logic [9:0]  cur_p, nxt_p;
    logic [3:0]  cur_s;
    logic        cur_dir, nxt_dir;
    logic [10:0] extent, limit;

    // Operand mux feeding the single shared step unit
    always_comb begin
        cur_p   = '0;
        cur_s   = '0;
        cur_dir = 1'b0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (idx == 3'(i)) begin
                cur_p   = (axis == AXIS_Y) ? wy[i*10 +: 10]      : wx[i*10 +: 10];
                cur_s   = (axis == AXIS_Y) ? speed_sh[i*8 +: 4]  : speed_sh[i*8+4 +: 4];
                cur_dir = (axis == AXIS_Y) ? wdy[i]              : wdx[i];
            end
        end
        extent = (axis == AXIS_Y) ? 11'(SPRITE_H) : 11'(SPRITE_W);
        limit  = (axis == AXIS_Y) ? 11'(SCREEN_H) : 11'(SCREEN_W);
    end

    axis_bounce_step u_step (
        .p        (cur_p),
        .s        (cur_s),
        .dir      (cur_dir),
        .extent   (extent),
        .limit    (limit),
        .p_next   (nxt_p),
        .dir_next (nxt_dir)
    );

`ifdef SPRITE_COLOR_CYCLE_EN
    localparam int unsigned CNT_W = (COLOR_INTERVAL > 1) ? $clog2(COLOR_INTERVAL) : 1;
    logic [CNT_W-1:0] frame_cnt;
`else
    assign color_state = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            axis     <= AXIS_X;
            idx      <= '0;
            speed_sh <= '0;
            wx       <= '0;
            wy       <= '0;
            wdx      <= '0;
            wdy      <= '0;
            pos_x    <= '0;
            pos_y    <= '0;
            dir_x    <= '0;
            dir_y    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
`ifdef SPRITE_COLOR_CYCLE_EN
            frame_cnt   <= '0;
            color_state <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        speed_sh <= speed_in;
                        wx       <= pos_x;
                        wy       <= pos_y;
                        wdx      <= dir_x;
                        wdy      <= dir_y;
                        idx      <= '0;
                        axis     <= AXIS_X;
                        busy     <= 1'b1;
                        state    <= STEP;
                    end
                end
                STEP: begin
                    if (frame_tick) overrun <= 1'b1;
                    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                        if (idx == 3'(i)) begin
                            if (axis == AXIS_X) begin
                                wx[i*10 +: 10] <= nxt_p;
                                wdx[i]         <= nxt_dir;
                            end else begin
                                wy[i*10 +: 10] <= nxt_p;
                                wdy[i]         <= nxt_dir;
                            end
                        end
                    end
                    if (axis == AXIS_X) begin
                        axis <= AXIS_Y;
                    end else begin
                        axis <= AXIS_X;
                        if (idx == 3'(NUM_SPRITES - 1)) state <= COMMIT;
                        else                            idx   <= idx + 3'd1;
                    end
                end
                COMMIT: begin
                    if (frame_tick) overrun <= 1'b1;
                    pos_x <= wx;
                    pos_y <= wy;
                    dir_x <= wdx;
                    dir_y <= wdy;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
`ifdef SPRITE_COLOR_CYCLE_EN
                    if (frame_cnt == CNT_W'(COLOR_INTERVAL - 1)) begin
                        frame_cnt   <= '0;
                        color_state <= color_state + 3'd1;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_sequencer.sv
// Self-checking bench for sprite_motion_sequencer: table-driven frames plus
// hand-written edge, overrun, colour and mid-sequence reset scenarios against a scoreboard.
module tb_sprite_motion_sequencer;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic [31:0]   speed_in = '0;
    logic [39:0]   pos_x, pos_y;
    logic [3:0]    dir_x, dir_y;
    logic [2:0]    color_state;
    logic          busy, done, overrun;

    sprite_motion_sequencer #(
        .NUM_SPRITES    (4),
        .SPRITE_W       (50),
        .SPRITE_H       (50),
        .COLOR_INTERVAL (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .speed_in    (speed_in),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .dir_x       (dir_x),
        .dir_y       (dir_y),
        .color_state (color_state),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model
    int mx[N], my[N];
    bit mdx[N], mdy[N];
    int mfr, mcol;

    typedef struct {
        logic [39:0] px, py;
        logic [3:0]  dx, dy;
        logic [2:0]  col;
    } exp_t;
    exp_t sbq[$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0;
        end
        mfr = 0; mcol = 0;
        sbq.delete();
    endtask

    task automatic model_axis(inout int p, inout bit d, input int s, input int ext, input int lim);
        if (s == 0) return;
        if (d == 0) begin
            if (p + ext + s <= lim) p = p + s;
            else d = 1;
        end else begin
            if (p >= s) p = p - s;
            else d = 0;
        end
    endtask

    task automatic model_frame(input logic [31:0] spd);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            model_axis(mx[i], mdx[i], int'(spd[8*i+4 +: 4]), 50, 640);
            model_axis(my[i], mdy[i], int'(spd[8*i +: 4]), 50, 480);
        end
`ifdef SPRITE_COLOR_CYCLE_EN
        mfr++;
        if (mfr == 16) begin
            mfr = 0;
            mcol = (mcol + 1) % 8;
        end
`endif
        for (int i = 0; i < N; i++) begin
            e.px[10*i +: 10] = 10'(mx[i]);
            e.py[10*i +: 10] = 10'(my[i]);
            e.dx[i] = mdx[i];
            e.dy[i] = mdy[i];
        end
        e.col = 3'(mcol);
        sbq.push_back(e);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending frame
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            done_seen++;
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected_done: got done with 0 pending, expected none");
            end else begin
                e = sbq.pop_front();
                check("sb_pos_x", 64'(pos_x), 64'(e.px));
                check("sb_pos_y", 64'(pos_y), 64'(e.py));
                check("sb_dir_x", 64'(dir_x), 64'(e.dx));
                check("sb_dir_y", 64'(dir_y), 64'(e.dy));
                check("sb_color", 64'(color_state), 64'(e.col));
            end
        end
    end

    // Called at a negedge; returns at the negedge after done
    task automatic run_frame(input logic [31:0] spd, input int hold);
        int lat;
        model_frame(spd);
        speed_in   = spd;
        frame_tick = 1'b1;
        @(negedge clk);
        check("busy_after_tick", 64'(busy), 64'd1);
        lat = 0;
        if (hold > 1) begin
            @(negedge clk);
            lat++;
        end
        frame_tick = 1'b0;
        speed_in   = $urandom;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd9);
        check("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pos_x"}, 64'(pos_x), 64'd0);
        check({tag, "_pos_y"}, 64'(pos_y), 64'd0);
        check({tag, "_dirs"}, 64'({dir_x, dir_y}), 64'd0);
        check({tag, "_color"}, 64'(color_state), 64'd0);
        check({tag, "_flags"}, 64'({busy, done, overrun}), 64'd0);
    endtask

    typedef struct {
        logic [31:0] spd;
        int          x0, y0;
        bit          dx0, dy0;
    } vec_t;
    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vecs[0] = '{32'h1F_5A_20_40, 4,  0, 1'b0, 1'b0};
        vecs[1] = '{32'h3C_07_91_35, 7,  5, 1'b0, 1'b0};
        vecs[2] = '{32'h00_E2_0F_F1, 22, 6, 1'b0, 1'b0};
        vecs[3] = '{32'hA5_11_44_02, 22, 8, 1'b0, 1'b0};
        vecs[4] = '{32'h00_00_00_00, 22, 8, 1'b0, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].spd, 1);
            check("vec_x0", 64'(pos_x[9:0]), 64'(vecs[v].x0));
            check("vec_y0", 64'(pos_y[9:0]), 64'(vecs[v].y0));
            check("vec_dx0", 64'(dir_x[0]), 64'(vecs[v].dx0));
            check("vec_dy0", 64'(dir_y[0]), 64'(vecs[v].dy0));
        end
        check("overrun_clear", 64'(overrun), 64'd0);

        // Right edge: 586+50+4 == 640 still fits, next move bounces
        do_reset();
        repeat (293) run_frame(32'h0000_0020, 1);
        check("x_at_586", 64'(pos_x[9:0]), 64'd586);
        run_frame(32'h0000_0040, 1);
        check("x_at_590", 64'(pos_x[9:0]), 64'd590);
        check("dir_still_right", 64'(dir_x[0]), 64'd0);
        run_frame(32'h0000_0040, 1);
        check("x_hold_590", 64'(pos_x[9:0]), 64'd590);
        check("dir_flip_left", 64'(dir_x[0]), 64'd1);
        run_frame(32'h0000_0040, 1);
        check("x_back_586", 64'(pos_x[9:0]), 64'd586);

        // Left edge: walk down to x=3 moving left, then speed 4 bounces
        repeat (38) run_frame(32'h0000_00F0, 1);
        check("x_at_16", 64'(pos_x[9:0]), 64'd16);
        run_frame(32'h0000_00D0, 1);
        check("x_at_3", 64'(pos_x[9:0]), 64'd3);
        check("dir_left_at_3", 64'(dir_x[0]), 64'd1);
        run_frame(32'h0000_0040, 1);
        check("x_hold_3", 64'(pos_x[9:0]), 64'd3);
        check("dir_flip_right", 64'(dir_x[0]), 64'd0);
        run_frame(32'h0000_0040, 1);
        check("x_at_7", 64'(pos_x[9:0]), 64'd7);

        // Overrun: tick held two cycles starts one sequence only
        d0 = done_seen;
        run_frame(32'h1111_1111, 2);
        check("overrun_set", 64'(overrun), 64'd1);
        repeat (15) @(negedge clk);
        check("one_sequence", 64'(done_seen - d0), 64'd1);
        run_frame(32'h0000_0000, 1);
        check("overrun_sticky", 64'(overrun), 64'd1);
        do_reset();
        check("overrun_reset", 64'(overrun), 64'd0);

        // Colour cycling
        repeat (15) run_frame(32'h0, 1);
        check("color_15", 64'(color_state), 64'd0);
        run_frame(32'h0, 1);
`ifdef SPRITE_COLOR_CYCLE_EN
        check("color_16", 64'(color_state), 64'd1);
`else
        check("color_16", 64'(color_state), 64'd0);
`endif
        repeat (112) run_frame(32'h0, 1);
        check("color_128", 64'(color_state), 64'd0);

        // Reset in the middle of a step sequence
        do_reset();
        run_frame(32'h0000_0077, 1);
        check("pre_abort_x0", 64'(pos_x[9:0]), 64'd7);
        speed_in   = 32'h0000_0055;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        run_frame(32'h0000_0040, 1);
        check("post_abort_x0", 64'(pos_x[9:0]), 64'd4);
        check("post_abort_y0", 64'(pos_y[9:0]), 64'd0);
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
